// File: rtl/hdmi_rx_d_edge_capture_pkg.sv
// Shared constants and edge-detect helper for the HDMI RX data edge-capture port.
package hdmi_rx_d_edge_capture_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RSVD     = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // Edge-type selection
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Per-bit edge detect between the current and previous synchronised sample.
  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int unsigned edge_type);
    logic [31:0] res;
    if (edge_type == EDGE_FALLING) begin
      res = ~cur & prev;
    end else if (edge_type == EDGE_ANY) begin
      res = cur ^ prev;
    end else begin
      res = cur & ~prev;
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_rx_d_edge_capture_if.sv
// Avalon-MM slave bus plus the external input bus and interrupt of the edge-capture port.
interface hdmi_rx_d_edge_capture_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] in_port;
  logic                  irq;

  modport master (
    output address, chipselect, write_n, writedata, in_port,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, in_port,
    output readdata, irq
  );
endinterface

// File: rtl/hdmi_rx_d_edge_capture_bus_synchronizer.sv
// Per-bit multi-flop synchroniser with asynchronous reset; every bit is independent.
module bus_synchronizer #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/hdmi_rx_d_edge_capture.sv
// Avalon-MM input port: synchronised DATA, sticky per-bit EDGE_CAPTURE, maskable level irq.
module hdmi_rx_d_edge_capture
  import hdmi_rx_d_edge_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING
) (
  input logic                      clk,
  input logic                      reset_n,
  hdmi_rx_d_edge_capture_if.slave  bus
);

  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);

  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0] edge_raw, clr;
  logic [WarmW-1:0]      warm_q, warm_d;
  logic                  warm_done;
  logic                  irq_q, irq_d;
  logic                  wr;
  logic [31:0]           rdata;

  bus_synchronizer #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.in_port),
    .q_o     (sync_q)
  );

  assign wr        = bus.chipselect & ~bus.write_n;
  assign warm_done = (warm_q == WarmW'(WarmMax));
  assign edge_raw  = DATA_WIDTH'(edge_detect(32'(sync_q), 32'(prev_q), EDGE_TYPE));

  // Next-state for warm-up counter, mask, sticky captures and irq
  always_comb begin
    warm_d = warm_done ? warm_q : warm_q + WarmW'(1);
    mask_d = mask_q;
    clr    = '0;
    if (wr && bus.address == ADDR_IRQ_MASK) begin
      mask_d = bus.writedata[DATA_WIDTH-1:0];
    end
    if (wr && bus.address == ADDR_EDGE_CAP) begin
      clr = bus.writedata[DATA_WIDTH-1:0];
    end
    // A fresh edge beats a same-cycle clear so no event is lost
    cap_d = (cap_q & ~clr) | (warm_done ? edge_raw : '0);
    irq_d = |(cap_q & mask_q);
  end

  // State registers; reset clears everything including the warm-up count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      warm_q <= warm_d;
      prev_q <= sync_q;
      mask_q <= mask_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  // Zero-latency read mux; reads have no side effects
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:     rdata[DATA_WIDTH-1:0] = sync_q;
      ADDR_IRQ_MASK: rdata[DATA_WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: rdata[DATA_WIDTH-1:0] = cap_q;
      default:       rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign bus.irq      = irq_q;

endmodule
